// File: rtl/taxi_irq_collect_pkg.sv
// taxi_irq_collect_pkg
//   Shared helpers for the interrupt collector and its round-robin selector.
//   No ports; imported by taxi_irq_collect and taxi_irq_rr_sel.
package taxi_irq_collect_pkg;

    // Width needed to hold values 0..v-1, never less than one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/taxi_axis_if.sv
// taxi_axis_if
//   Minimal AXI-stream bundle.
//   src modport: drives tdata/tkeep/tvalid/tlast/tid/tdest/tuser, samples tready.
//   snk modport: the mirror image.
interface taxi_axis_if #(
    parameter int DATA_W = 8,
    parameter int KEEP_W = (DATA_W + 7) / 8,
    parameter int ID_W   = 1,
    parameter int DEST_W = 1,
    parameter int USER_W = 1
);
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [ID_W-1:0]   tid;
    logic [DEST_W-1:0] tdest;
    logic [USER_W-1:0] tuser;

    modport src (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input tready);
    modport snk (input tdata, tkeep, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/taxi_irq_rr_sel.sv
// taxi_irq_rr_sel
//   Combinational round-robin pick: first set bit of req searching upward
//   from (last+1) mod N, wrapping.
//   req   in  N      request vector
//   last  in  SEL_W  index granted most recently
//   valid out 1      some request is set
//   index out SEL_W  chosen request (always < N)
module taxi_irq_rr_sel
    import taxi_irq_collect_pkg::*;
#(
    parameter int N = 32,
    localparam int SEL_W = clog2_min1(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] last,
    output logic             valid,
    output logic [SEL_W-1:0] index
);
    logic [2*N-1:0] dbl;
    int             start;
    logic           found;

    assign dbl = {req, req};

    // Window [start, start+N) over the doubled vector sees every bit exactly
    // once in rotated order, so the lowest hit is the round-robin winner.
    always_comb begin
        start = (int'(last) >= N - 1) ? 0 : int'(last) + 1;
        found = 1'b0;
        index = '0;
        for (int j = 0; j < 2 * N; j++) begin
            if (!found && j >= start && j < start + N && dbl[j]) begin
                found = 1'b1;
                index = SEL_W'((j >= N) ? j - N : j);
            end
        end
        valid = found;
    end
endmodule

// File: rtl/taxi_irq_collect.sv
// taxi_irq_collect
//   Gathers raw interrupt lines into a pending register and issues one
//   vector index per beat on an AXI stream, round-robin, with an optional
//   minimum gap between grants. Repeat requests coalesce while pending.
//   clk          in   1            clock
//   rst          in   1            async active-high reset
//   irq_in       in   IRQ_N        request lines (high = one request)
//   enable       in   1            grant enable (pending still accumulates)
//   m_axis_irq   src  IRQ_INDEX_W  interrupt index stream
//   irq_pending  out  IRQ_N        pending register
module taxi_irq_collect
    import taxi_irq_collect_pkg::*;
#(
    parameter int IRQ_N   = 32,
    parameter int IRQ_GAP = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IRQ_N-1:0] irq_in,
    input  logic             enable,
    taxi_axis_if.src         m_axis_irq,
    output logic [IRQ_N-1:0] irq_pending
);
    localparam int IRQ_INDEX_W = m_axis_irq.DATA_W;
    localparam int GAP_W       = clog2_min1(IRQ_GAP + 1);
    localparam int SEL_W       = clog2_min1(IRQ_N);

    if (IRQ_INDEX_W > 11 || (2 ** IRQ_INDEX_W) < IRQ_N) begin : g_bad_cfg
        $fatal(1, "taxi_irq_collect: index width cannot address IRQ_N vectors");
    end

    // Reset asserts at once, releases two clocks after rst falls.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_int;

    assign rst_sync_d = {rst_sync_q[0], 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rst_sync_q <= 2'b11;
        else     rst_sync_q <= rst_sync_d;
    end

    assign rst_int = rst_sync_q[1];

    logic [IRQ_N-1:0]       pending_q, pending_d;
    logic                   tvalid_q, tvalid_d;
    logic [IRQ_INDEX_W-1:0] tdata_q, tdata_d;
    logic [SEL_W-1:0]       last_q, last_d;
    logic [GAP_W-1:0]       gap_q, gap_d;

    logic                   sel_valid;
    logic [SEL_W-1:0]       sel_idx;
    logic                   grant;
    logic [IRQ_N-1:0]       grant_vec;

    taxi_irq_rr_sel #(.N(IRQ_N)) u_sel (
        .req   (pending_q),
        .last  (last_q),
        .valid (sel_valid),
        .index (sel_idx)
    );

    // Only the registered pending set competes; this cycle's irq_in waits.
    assign grant = enable && (gap_q == '0) && (!tvalid_q || m_axis_irq.tready) && sel_valid;

    always_comb begin
        grant_vec = '0;
        if (grant) grant_vec[sel_idx] = 1'b1;

        // A request arriving with its own grant re-arms the bit.
        pending_d = irq_in | (pending_q & ~grant_vec);

        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        last_d   = last_q;
        if (grant) begin
            tvalid_d = 1'b1;
            tdata_d  = IRQ_INDEX_W'(sel_idx);
            last_d   = sel_idx;
        end else if (m_axis_irq.tready) begin
            tvalid_d = 1'b0;
        end

        if (grant)              gap_d = GAP_W'(IRQ_GAP);
        else if (gap_q != '0)   gap_d = gap_q - 1'b1;
        else                    gap_d = gap_q;
    end

    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            pending_q <= '0;
            tvalid_q  <= 1'b0;
            tdata_q   <= '0;
            last_q    <= SEL_W'(IRQ_N - 1);
            gap_q     <= '0;
        end else begin
            pending_q <= pending_d;
            tvalid_q  <= tvalid_d;
            tdata_q   <= tdata_d;
            last_q    <= last_d;
            gap_q     <= gap_d;
        end
    end

    assign m_axis_irq.tvalid = tvalid_q;
    assign m_axis_irq.tdata  = tdata_q;
    assign m_axis_irq.tlast  = 1'b1;
    assign m_axis_irq.tkeep  = '1;
    assign m_axis_irq.tid    = '0;
    assign m_axis_irq.tdest  = '0;
    assign m_axis_irq.tuser  = '0;
    assign irq_pending       = pending_q;
endmodule

// File: tb/tb_taxi_irq_collect.sv
module tb_taxi_irq_collect;
    localparam int N = 32;
    localparam int W = 5;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0] irq_in, irq_in_g, pend, pend_g;
    logic enable, enable_g;

    always #5 clk = ~clk;

    taxi_axis_if #(.DATA_W(W)) ax ();
    taxi_axis_if #(.DATA_W(W)) ax_g ();

    taxi_irq_collect #(.IRQ_N(N), .IRQ_GAP(0)) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .enable(enable),
        .m_axis_irq(ax), .irq_pending(pend)
    );

    taxi_irq_collect #(.IRQ_N(N), .IRQ_GAP(4)) dut_g (
        .clk(clk), .rst(rst), .irq_in(irq_in_g), .enable(enable_g),
        .m_axis_irq(ax_g), .irq_pending(pend_g)
    );

    int nerr = 0;
    int nchk = 0;

    // Reference for the IRQ_GAP=0 instance: set of pending vectors, the last
    // vector issued and the beat currently offered downstream.
    logic [N-1:0] m_pend;
    int           m_last;
    bit           m_v;
    int           m_d;

    function automatic int m_find();
        for (int k = 1; k <= N; k++) begin
            if (m_pend[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    task automatic m_reset();
        m_pend = '0; m_last = N - 1; m_v = 0; m_d = 0;
    endtask

    // Apply one cycle of inputs, advance the model, land 1 time unit past the edge.
    task automatic step(input logic [N-1:0] irq, input bit en, input bit rdy);
        int f;
        irq_in = irq; enable = en; ax.tready = rdy;
        f = m_find();
        if (en && (!m_v || rdy) && f >= 0) begin
            m_pend[f] = 1'b0; m_v = 1; m_d = f; m_last = f;
        end else if (rdy) begin
            m_v = 0;
        end
        m_pend = m_pend | irq;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; irq_in = '0; irq_in_g = '0; enable = 1'b1; enable_g = 1'b1;
        ax.tready = 1'b1; ax_g.tready = 1'b1;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        nchk++; if (ax.tvalid !== 1'b0) begin nerr++; $display("FAIL reset_tvalid got=%b want=0", ax.tvalid); end
        nchk++; if (ax.tdata !== '0) begin nerr++; $display("FAIL reset_tdata got=%0d want=0", ax.tdata); end
        nchk++; if (pend !== '0) begin nerr++; $display("FAIL reset_pending got=%h want=0", pend); end
        rst = 1'b0;
        repeat (3) step('0, 1, 1);
        nchk++; if (ax.tvalid !== 1'b0) begin nerr++; $display("FAIL idle_tvalid got=%b want=0", ax.tvalid); end
    endtask

    task automatic test_single();
        step(32'h1 << 5, 1, 1);
        nchk++; if (pend !== (32'h1 << 5)) begin nerr++; $display("FAIL single_pend got=%h want=%h", pend, 32'h20); end
        nchk++; if (ax.tvalid !== 1'b0) begin nerr++; $display("FAIL single_early got=%b want=0", ax.tvalid); end
        step('0, 1, 1);
        nchk++; if (ax.tvalid !== 1'b1 || ax.tdata !== 5'd5) begin
            nerr++; $display("FAIL single_beat got v=%b d=%0d want v=1 d=5", ax.tvalid, ax.tdata); end
        nchk++; if (ax.tlast !== 1'b1 || ax.tkeep !== 1'b1 || ax.tuser !== 1'b0) begin
            nerr++; $display("FAIL single_fields got last=%b keep=%b user=%b want 1,1,0", ax.tlast, ax.tkeep, ax.tuser); end
        nchk++; if (pend[5] !== 1'b0) begin nerr++; $display("FAIL single_clear got=%b want=0", pend[5]); end
        step('0, 1, 1);
        nchk++; if (ax.tvalid !== 1'b0) begin nerr++; $display("FAIL single_drop got=%b want=0", ax.tvalid); end
    endtask

    task automatic test_back_to_back();
        int exp_seq [4] = '{0, 4, 0, 4};
        for (int r = 0; r < 2; r++) begin
            step(32'h11, 1, 1);
            for (int b = 0; b < 2; b++) begin
                step('0, 1, 1);
                nchk++; if (ax.tvalid !== 1'b1 || int'(ax.tdata) != exp_seq[r*2+b]) begin
                    nerr++; $display("FAIL b2b_beat%0d got v=%b d=%0d want v=1 d=%0d", r*2+b, ax.tvalid, ax.tdata, exp_seq[r*2+b]); end
            end
            step('0, 1, 1);
            nchk++; if (ax.tvalid !== 1'b0) begin nerr++; $display("FAIL b2b_end got=%b want=0", ax.tvalid); end
        end
    endtask

    task automatic test_coalesce();
        for (int c = 0; c < 5; c++) step(32'h1 << 3, 1, 0);
        nchk++; if (ax.tvalid !== 1'b1 || ax.tdata !== 5'd3 || pend[3] !== 1'b1) begin
            nerr++; $display("FAIL coal_hold got v=%b d=%0d p3=%b want 1,3,1", ax.tvalid, ax.tdata, pend[3]); end
        step('0, 1, 1);
        nchk++; if (ax.tvalid !== 1'b1 || ax.tdata !== 5'd3 || pend[3] !== 1'b0) begin
            nerr++; $display("FAIL coal_second got v=%b d=%0d p3=%b want 1,3,0", ax.tvalid, ax.tdata, pend[3]); end
        step('0, 1, 1);
        nchk++; if (ax.tvalid !== 1'b0) begin nerr++; $display("FAIL coal_once got=%b want=0", ax.tvalid); end
    endtask

    task automatic test_backpressure();
        int exp_seq [3] = '{12, 20, 2};
        int held = 0;
        step(32'h1 << 7, 1, 0);
        step((32'h1 << 2) | (32'h1 << 12) | (32'h1 << 20), 1, 0);
        for (int c = 0; c < 20; c++) begin
            if (ax.tvalid === 1'b1 && ax.tdata === 5'd7) held++;
            step('0, 1, 0);
        end
        nchk++; if (held != 20) begin nerr++; $display("FAIL bp_hold got=%0d want=20", held); end
        for (int b = 0; b < 3; b++) begin
            step('0, 1, 1);
            nchk++; if (ax.tvalid !== 1'b1 || int'(ax.tdata) != exp_seq[b]) begin
                nerr++; $display("FAIL bp_next%0d got v=%b d=%0d want v=1 d=%0d", b, ax.tvalid, ax.tdata, exp_seq[b]); end
        end
        step('0, 1, 1);
        nchk++; if (ax.tvalid !== 1'b0) begin nerr++; $display("FAIL bp_end got=%b want=0", ax.tvalid); end
    endtask

    task automatic test_gap();
        int cyc [$];
        int dat [$];
        irq_in_g = 32'h7;
        step('0, 1, 1);
        irq_in_g = '0;
        for (int c = 0; c < 25; c++) begin
            step('0, 1, 1);
            if (ax_g.tvalid === 1'b1) begin cyc.push_back(c); dat.push_back(int'(ax_g.tdata)); end
        end
        nchk++; if (cyc.size() != 3) begin
            nerr++; $display("FAIL gap_count got=%0d want=3", cyc.size());
        end else begin
            for (int b = 0; b < 3; b++) begin
                nchk++; if (dat[b] != b) begin nerr++; $display("FAIL gap_data%0d got=%0d want=%0d", b, dat[b], b); end
            end
            nchk++; if (cyc[1] - cyc[0] != 5 || cyc[2] - cyc[1] != 5) begin
                nerr++; $display("FAIL gap_spacing got=%0d,%0d want=5,5", cyc[1] - cyc[0], cyc[2] - cyc[1]); end
        end
    endtask

    task automatic test_enable_and_rst();
        step(32'h1 << 9, 0, 1);
        repeat (3) step('0, 0, 1);
        nchk++; if (ax.tvalid !== 1'b0 || pend[9] !== 1'b1) begin
            nerr++; $display("FAIL en_block got v=%b p9=%b want 0,1", ax.tvalid, pend[9]); end
        step(32'h1 << 1, 1, 0);
        nchk++; if (ax.tvalid !== 1'b1 || ax.tdata !== 5'd9) begin
            nerr++; $display("FAIL en_grant got v=%b d=%0d want 1,9", ax.tvalid, ax.tdata); end
        #2 rst = 1'b1;
        #1;
        nchk++; if (ax.tvalid !== 1'b0 || pend !== '0 || ax.tdata !== '0) begin
            nerr++; $display("FAIL async_rst got v=%b p=%h d=%0d want 0,0,0", ax.tvalid, pend, ax.tdata); end
        irq_in = '0;
        m_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) step('0, 1, 1);
    endtask

    task automatic test_random();
        int bad = 0;
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] r;
            r = $urandom & $urandom & $urandom;
            step(r, ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0));
            nchk++;
            if (ax.tvalid !== m_v || int'(ax.tdata) != m_d || pend !== m_pend) begin
                nerr++; bad++;
                if (bad < 10)
                    $display("FAIL rand_c%0d got v=%b d=%0d p=%h want v=%b d=%0d p=%h",
                             c, ax.tvalid, ax.tdata, pend, m_v, m_d, m_pend);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_coalesce();
        test_backpressure();
        test_gap();
        test_enable_and_rst();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
